// File: rtl/accum_checker.sv
// ---------------------------------------------------------------------------
// accum_checker
//
// Purpose: self-checking stage placed downstream of the protected
// accumulator. It watches the accumulator's drive and outputs every cycle,
// verifies the registered path by cycle-to-cycle deltas and the bypass mux
// combinationally, and reports a verdict after a fixed-length run.
//
// Parameters:
//   SECRET      constant the accumulator adds every cycle
//   NUM_CHECKS  checks per run (1..65535)
//
// Ports:
//   clk               clock, all state updates on posedge
//   rst               synchronous active-high reset (priority over start)
//   start             begin a run, honoured only in IDLE or DONE
//   accum_in          value driven into the accumulator this cycle
//   accum_bypass      bypass select driven into the accumulator this cycle
//   accum_out         accumulator registered output
//   accum_bypass_out  accumulator mixed-path output
//   busy              run in progress
//   done              run finished, holds until start or rst
//   pass              valid with done, 1 iff err_count == 0
//   err_count         failed checks, saturating at 255
//   first_err         check index of first failure, 16'hFFFF = none
//   check_count       checks completed in current or last run
// ---------------------------------------------------------------------------
module accum_checker #(
  parameter logic [31:0] SECRET     = 32'd7,
  parameter int unsigned NUM_CHECKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] accum_in,
  input  logic        accum_bypass,
  input  logic [31:0] accum_out,
  input  logic [31:0] accum_bypass_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] first_err,
  output logic [15:0] check_count
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_CHECKS - 1);
  localparam logic [15:0] NO_ERR   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Saturating add of this cycle's failure count onto the error counter.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, b};
    if (sum[8]) begin
      return 8'hFF;
    end else begin
      return sum[7:0];
    end
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic        launch_s;
  logic [31:0] prev_out_r;
  logic [31:0] prev_in_r;
  logic        busy_r;
  logic        done_r;
  logic        pass_r;
  logic [7:0]  err_count_r;
  logic [15:0] first_err_r;
  logic [15:0] check_count_r;

  logic [31:0] seq_exp_s;
  logic        seq_fail_s;
  logic [31:0] byp_exp_s;
  logic        byp_fail_s;
  logic [1:0]  n_fail_s;
  logic [7:0]  err_next_s;
  logic        last_s;

  // Check evaluation: sequential delta (mod 2^32) and bypass mux selection.
  always_comb begin
    seq_exp_s  = prev_out_r + prev_in_r + SECRET;
    seq_fail_s = (accum_out != seq_exp_s);
    if (accum_bypass) begin
      byp_exp_s = accum_in;
    end else begin
      byp_exp_s = accum_out;
    end
    byp_fail_s = (accum_bypass_out != byp_exp_s);
    n_fail_s   = {1'b0, seq_fail_s} + {1'b0, byp_fail_s};
    err_next_s = sat_add8(err_count_r, n_fail_s);
    last_s     = (check_count_r == LAST_IDX);
  end

  // Next-state logic; launch_s marks the capture cycle of a new run.
  always_comb begin
    state_s  = state_r;
    launch_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s  = ST_RUN;
          launch_s = 1'b1;
        end else begin
          state_s  = state_r;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, capture registers and result counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      prev_out_r    <= 32'd0;
      prev_in_r     <= 32'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      err_count_r   <= 8'd0;
      first_err_r   <= NO_ERR;
      check_count_r <= 16'd0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
      if (launch_s) begin
        // Capture cycle only: no check is performed here.
        prev_out_r    <= accum_out;
        prev_in_r     <= accum_in;
        pass_r        <= 1'b0;
        err_count_r   <= 8'd0;
        first_err_r   <= NO_ERR;
        check_count_r <= 16'd0;
      end else if (state_r == ST_RUN) begin
        prev_out_r    <= accum_out;
        prev_in_r     <= accum_in;
        err_count_r   <= err_next_s;
        check_count_r <= check_count_r + 16'd1;
        if ((n_fail_s != 2'd0) && (first_err_r == NO_ERR)) begin
          first_err_r <= check_count_r;
        end
        if (last_s) begin
          // Verdict uses the count including this final check.
          pass_r <= (err_next_s == 8'd0);
        end
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign err_count   = err_count_r;
  assign first_err   = first_err_r;
  assign check_count = check_count_r;

endmodule

// File: doc/accum_checker.md
# accum_checker

Downstream self-checking stage for the protected accumulator block. It samples the accumulator's drive (`accum_in`, `accum_bypass`) and its outputs (`accum_out`, `accum_bypass_out`) every cycle. It verifies the sequential path by cycle-to-cycle deltas and the bypass mux combinationally, over a fixed-length run. It reports a registered error count, the first failing check index and a pass/done verdict to the enclosing testbench top.

## Interface
- `SECRET`, 32'd7: constant the accumulator adds every cycle.
- `NUM_CHECKS`, 16: checks per run; legal range 1..65535.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; honoured only in IDLE or DONE.
- `accum_in`  in  32  value driven into the accumulator this cycle.
- `accum_bypass`  in  1  bypass select driven into the accumulator this cycle.
- `accum_out`  in  32  accumulator registered output.
- `accum_bypass_out`  in  32  accumulator mixed-path output.
- `busy`  out  1  run in progress (state RUN).
- `done`  out  1  run finished; holds until `start` or `rst`.
- `pass`  out  1  valid when `done`; 1 iff `err_count == 0`.
- `err_count`  out  8  failed checks, saturating at 255.
- `first_err`  out  16  check index of first failure; 16'hFFFF = none.
- `check_count`  out  16  checks completed in current or last run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: waits for `start`.
  - On `start`: capture `prev_out <= accum_out` and `prev_in <= accum_in`.
  - Clear `err_count`, `check_count`; set `first_err` to FFFF; go to RUN.
- RUN: each cycle performs check index `k = check_count`.
  - Sequential check fails if `accum_out != prev_out + prev_in + SECRET`, computed mod 2^32 (carry discarded; wrap is legal).
  - Bypass check fails if `accum_bypass_out != (accum_bypass ? accum_in : accum_out)`.
  - `err_count` increases by the number of failing checks this cycle (0, 1 or 2), saturating at 255.
  - If any check fails and `first_err == FFFF`, `first_err <= k`.
  - Update `prev_out`/`prev_in` from the current inputs; `check_count <= k+1`.
  - When `k == NUM_CHECKS-1`, go to DONE after this check.
- `start` during RUN: ignored.
- DONE: all outputs hold.
  - `start` restarts exactly as from IDLE, including the capture cycle.
- `rst` (any state, including mid-RUN) has priority over `start`:
  - next state IDLE; `busy=0`, `done=0`, `pass=0`, `err_count=0`, `check_count=0`, `first_err=FFFF`; `prev_*` cleared to 0.

## Timing
- All outputs registered; reset values as listed above.
- Start cycle S (start sampled high): capture only, no check.
- Checks occur on cycles S+1 .. S+NUM_CHECKS.
- The result of the check on cycle c is visible on outputs at c+1.
- `busy` is high on cycles S+1 .. S+NUM_CHECKS.
- `done` and `pass` rise on S+NUM_CHECKS+1, together with final counts.
- Restart from DONE: `done` drops on the cycle after `start`, `busy` rises on that same cycle.
- The checker is purely observational and never drives the accumulator.

## Test plan
- Clean run: after `rst`, pulse `start`; constant `accum_in=1`, `accum_bypass=0`, accumulator behaving correctly, `NUM_CHECKS=16`. Expect `done=1` and `pass=1` on S+17; `err_count=0`, `first_err=FFFF`, `check_count=16`.
- Single corruption: `accum_bypass=1` throughout; force `accum_out` +1 on check 5 only. Expect two sequential failures (checks 5 and 6); `err_count=2`, `first_err=5`, `pass=0`.
- Wrap-around: `prev_out=32'hFFFF_FFF0`, `prev_in=32'h10`, `SECRET=7`, `accum_out=32'h7`. Expect no error; `pass=1`.
- Bypass fault: accumulator returns `accum_out` instead of `accum_in` when `accum_bypass=1`, with bypass asserted on checks 2, 9 and 11 and `accum_in != accum_out` on those checks. Expect `err_count=3`, `first_err=2`.
- Saturation: `NUM_CHECKS=200`, both checks fail every cycle. Expect `err_count=255` from check 127 onward; final value still 255; `first_err=0`.
- Reset mid-run: assert `rst` during check 8. Expect IDLE with all outputs at reset values the next cycle. A following `start` with a correct accumulator completes a fresh run with `pass=1` and `check_count=NUM_CHECKS`.
